// File: rtl/vga_timing_gen_if.sv
// Raster outputs of the VGA timing generator as seen by the graphics engine and sync pins.
interface vga_timing_gen_if;
    logic       pix_stb;
    logic [9:0] x;
    logic [8:0] y;
    logic       frame_active;
    logic       h_sync;
    logic       v_sync;
    logic       frame_start;

    modport master (
        output pix_stb, x, y, frame_active, h_sync, v_sync, frame_start
    );

    modport slave (
        input  pix_stb, x, y, frame_active, h_sync, v_sync, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, sync pulses, active flag and pixel coordinates,
// all registered one strobe behind the counters so every output is glitch-free.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CLK_DIV  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS_C    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE_C    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS_C    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE_C    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic       toggle_r;
    logic       pix_stb_s;

    logic       frame_active_s;
    logic       h_sync_s;
    logic       v_sync_s;
    logic       frame_start_s;

    logic [9:0] x_r;
    logic [8:0] y_r;
    logic       frame_active_r;
    logic       h_sync_r;
    logic       v_sync_r;
    logic       frame_start_r;

    // At CLK_DIV=2 the toggle register itself is the strobe, so it is glitch-free too.
    assign pix_stb_s = (CLK_DIV == 1) ? 1'b1 : toggle_r;

    // Pixel strobe divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_r <= 1'b0;
        end else begin
            toggle_r <= (CLK_DIV == 2) ? ~toggle_r : 1'b0;
        end
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (pix_stb_s) begin
            if (h_cnt_r == H_LAST_C) begin
                h_cnt_r <= 10'd0;
                if (v_cnt_r == V_LAST_C) begin
                    v_cnt_r <= 10'd0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Decode of the current counter position; registered below.
    always_comb begin
        frame_active_s = 1'b0;
        h_sync_s       = ~SYNC_ACT;
        v_sync_s       = ~SYNC_ACT;
        frame_start_s  = 1'b0;
        frame_active_s = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        if ((h_cnt_r >= H_SS_C) && (h_cnt_r < H_SE_C)) begin
            h_sync_s = SYNC_ACT;
        end else begin
            h_sync_s = ~SYNC_ACT;
        end
        if ((v_cnt_r >= V_SS_C) && (v_cnt_r < V_SE_C)) begin
            v_sync_s = SYNC_ACT;
        end else begin
            v_sync_s = ~SYNC_ACT;
        end
        frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    end

    // Output registers, loaded only on strobe clocks so outputs hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r            <= 10'd0;
            y_r            <= 9'd0;
            frame_active_r <= 1'b0;
            h_sync_r       <= ~SYNC_ACT;
            v_sync_r       <= ~SYNC_ACT;
            frame_start_r  <= 1'b0;
        end else if (pix_stb_s) begin
            x_r            <= h_cnt_r;
            y_r            <= v_cnt_r[8:0];
            frame_active_r <= frame_active_s;
            h_sync_r       <= h_sync_s;
            v_sync_r       <= v_sync_s;
            frame_start_r  <= frame_start_s;
        end else begin
            x_r            <= x_r;
            y_r            <= y_r;
            frame_active_r <= frame_active_r;
            h_sync_r       <= h_sync_r;
            v_sync_r       <= v_sync_r;
            frame_start_r  <= frame_start_r;
        end
    end

    assign vga.pix_stb      = pix_stb_s;
    assign vga.x            = x_r;
    assign vga.y            = y_r;
    assign vga.frame_active = frame_active_r;
    assign vga.h_sync       = h_sync_r;
    assign vga.v_sync       = v_sync_r;
    assign vga.frame_start  = frame_start_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench comparing five generator configurations (full VGA and a shrunken
// raster, both strobe rates, both sync polarities) against an arithmetic raster model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   k;
    int   checks = 0;
    int   errors = 0;
    int   fa_cnt = 0;
    int   vsl_cnt = 0;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if2 ();
    vga_timing_gen_if if3 ();
    vga_timing_gen_if if4 ();

    vga_timing_gen u0 (.clk(clk), .rst_n(rst_n), .vga(if0));
    vga_timing_gen #(.CLK_DIV(2)) u1 (.clk(clk), .rst_n(rst_n), .vga(if1));
    vga_timing_gen #(.SYNC_POL(1)) u2 (.clk(clk), .rst_n(rst_n), .vga(if2));
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3))
        u3 (.clk(clk), .rst_n(rst_n), .vga(if3));
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .SYNC_POL(1), .CLK_DIV(2))
        u4 (.clk(clk), .rst_n(rst_n), .vga(if4));

    logic [23:0] obs [5];
    assign obs[0] = {if0.pix_stb, if0.x, if0.y, if0.frame_active, if0.h_sync, if0.v_sync, if0.frame_start};
    assign obs[1] = {if1.pix_stb, if1.x, if1.y, if1.frame_active, if1.h_sync, if1.v_sync, if1.frame_start};
    assign obs[2] = {if2.pix_stb, if2.x, if2.y, if2.frame_active, if2.h_sync, if2.v_sync, if2.frame_start};
    assign obs[3] = {if3.pix_stb, if3.x, if3.y, if3.frame_active, if3.h_sync, if3.v_sync, if3.frame_start};
    assign obs[4] = {if4.pix_stb, if4.x, if4.y, if4.frame_active, if4.h_sync, if4.v_sync, if4.frame_start};

    always #5 clk = ~clk;

    // Clocks elapsed since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {pix_stb,x,y,frame_active,h_sync,v_sync,frame_start} after kk clocks out of reset.
    function automatic logic [23:0] exp_out(input int id, input int kk);
        int ha = 640, hfp = 16, hsw = 96, hbp = 48;
        int va = 480, vfp = 10, vsw = 2, vbp = 33;
        int div = 1;
        logic pol = 1'b0;
        int ht, vt, s, p, h, v;
        logic ps, fa, hs, vs, fs;
        case (id)
            1: div = 2;
            2: pol = 1'b1;
            3: begin ha = 16; hfp = 2; hsw = 4; hbp = 3; va = 6; vfp = 2; vsw = 2; vbp = 3; end
            4: begin ha = 16; hfp = 2; hsw = 4; hbp = 3; va = 6; vfp = 2; vsw = 2; vbp = 3;
                     pol = 1'b1; div = 2; end
            default: div = 1;
        endcase
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        s  = (div == 1) ? kk : kk / 2;
        ps = (div == 1) ? 1'b1 : ((kk % 2) == 1);
        if (s == 0) return {ps, 10'd0, 9'd0, 1'b0, ~pol, ~pol, 1'b0};
        p  = s - 1;
        h  = p % ht;
        v  = (p / ht) % vt;
        fa = (h < ha) && (v < va);
        hs = ((h >= ha + hfp) && (h < ha + hfp + hsw)) ? pol : ~pol;
        vs = ((v >= va + vfp) && (v < va + vfp + vsw)) ? pol : ~pol;
        fs = (h == 0) && (v == 0);
        return {ps, 10'(h), 9'(v % 512), fa, hs, vs, fs};
    endfunction

    task automatic check_reset_all(input string tag);
        for (int id = 0; id < 5; id++)
            check($sformatf("%s_u%0d", tag, id), {8'd0, obs[id]}, {8'd0, exp_out(id, 0)});
    endtask

    // Per-clock comparison of every instance against the model, plus landmark checks.
    initial begin
        forever begin
            @(negedge clk);
            for (int id = 0; id < 5; id++)
                check($sformatf("u%0d_k%0d", id, k), {8'd0, obs[id]}, {8'd0, exp_out(id, k)});
            if (k == 1) check("u0_first_fs", {31'd0, if0.frame_start}, 32'd1);
            if (k == 640) check("u0_last_active", {21'd0, if0.x, if0.frame_active}, {21'd0, 10'd639, 1'b1});
            if (k == 641) check("u0_blank", {31'd0, if0.frame_active}, 32'd0);
            if (k == 801) check("u0_wrap_xy", {13'd0, if0.x, if0.y}, {13'd0, 10'd0, 9'd1});
            if (k == 0) begin
                fa_cnt  = 0;
                vsl_cnt = 0;
            end else if (k <= 325) begin
                fa_cnt  += int'(if3.frame_active);
                vsl_cnt += int'(!if3.v_sync);
                if (k == 325) begin
                    check("u3_frame_active_cnt", fa_cnt, 96);
                    check("u3_vsync_low_cnt", vsl_cnt, 50);
                end
            end
            if (k == 326) check("u3_next_fs", {31'd0, if3.frame_start}, 32'd1);
        end
    end

    // Reset sequencing: initial reset, a mid-sync reset, then randomized reset epochs.
    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_reset_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3400) @(posedge clk);

        n = 0;
        while (if4.v_sync !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("u4_vsync_reached", {31'd0, if4.v_sync}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("u4_vsync_async_off", {31'd0, if4.v_sync}, 32'd0);
        check_reset_all("rst_mid");
        repeat ($urandom_range(1, 5)) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int e = 0; e < 8; e++) begin
            repeat ($urandom_range(20, 3000)) @(posedge clk);
            @(posedge clk);
            #($urandom_range(1, 3)) rst_n = 1'b0;
            #1 check_reset_all($sformatf("rst_async%0d", e));
            repeat ($urandom_range(1, 5)) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (400) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
